cpu_bus_resp: RTL and testbench
===============================

# cpu_bus_resp

Synthesizable responder for the CPU memory bus: the memory end of the CPU-to-memory interface. It serves CPU requests from a 2 KB mirrored internal RAM, forwards PPU register accesses ($2000–$3FFF) over a handshake to the PPU side, and returns open-bus data for unmapped addresses. It replaces the behavioural memory model in the DUV path and sits between `cpu_duv_top` and the PPU.

## Interface
- `RAM_AW`, 11, internal RAM address width (2**RAM_AW bytes, mirrored across $0000–$1FFF)
- `PPU_TIMEOUT`, 16, max cycles in PPU_WAIT before forced completion (>=2)
- `clk`  in  1  clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  request; held high with stable addr/we/wdata until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  16  byte address
- `cpu_wdata`  in  8  write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  8  read data; valid in `cpu_ack` cycle, held until next ack
- `ppu_req`  out  1  PPU register request; held until `ppu_ack` or timeout
- `ppu_we`  out  1  PPU write
- `ppu_addr`  out  3  register index = `cpu_addr[2:0]`
- `ppu_wdata`  out  8  PPU write data
- `ppu_ack`  in  1  PPU completion; `ppu_rdata` sampled in same cycle
- `ppu_rdata`  in  8  PPU read data
- `to_cnt`  out  8  saturating PPU timeout counter

## Operation
- Decode: $0000–$1FFF → RAM, index `cpu_addr[RAM_AW-1:0]`; $2000–$3FFF → PPU, every 8 bytes mirrored; all else → unmapped.
- FSM states: IDLE, RAM_ACC, PPU_WAIT, RESP.
  - IDLE: `cpu_req`=1 → RAM_ACC (RAM) / PPU_WAIT (PPU) / RESP (unmapped); otherwise stay.
  - RAM_ACC: synchronous RAM read or write performed; → RESP.
  - PPU_WAIT: `ppu_req`=1; `ppu_ack`=1 → capture `ppu_rdata` (read), → RESP; wait counter reaches PPU_TIMEOUT → `to_cnt`++ (saturate at 255), → RESP.
  - RESP: `cpu_ack`=1 for exactly this cycle; → IDLE unconditionally.
- Read data: RAM byte; PPU captured byte; on timeout or unmapped read, the open-bus latch value.
- Open-bus latch: updated in every RESP cycle with `cpu_rdata` (reads) or `cpu_wdata` (writes). Reset value 0x00.
- Unmapped writes: no side effect besides open-bus update; acked normally.
- `ppu_addr`, `ppu_we`, `ppu_wdata` registered on IDLE→PPU_WAIT; stable while `ppu_req`=1.
- `cpu_req` deasserted before `cpu_ack` is a protocol violation; behaviour undefined, no recovery required.
- RAM contents are not cleared by reset.

## Timing
- Reset: state IDLE; `cpu_ack`=0, `cpu_rdata`=0x00, `ppu_req`=0, `ppu_we`=0, `ppu_addr`=0, `ppu_wdata`=0x00, `to_cnt`=0, open-bus=0x00, wait counter=0.
- Reset asserted in any state: the outputs above hold their reset values from the next edge. An in-flight PPU request is dropped without ack. A pending CPU request is not acked.
- Request sampled at edge T (IDLE).
  - RAM: `cpu_ack` at cycle T+2.
  - Unmapped: `cpu_ack` at cycle T+1.
  - PPU: `ppu_req` high from T+1. If `ppu_ack` is sampled at edge U, `cpu_ack` is at cycle U+1 and `ppu_req` is low from U+1. A `ppu_ack` in the same cycle as `ppu_req` first rises is valid.
- Timeout: wait counter clears on PPU_WAIT entry and increments each PPU_WAIT cycle. With no ack, `ppu_req` is high for exactly PPU_TIMEOUT cycles and `cpu_ack` follows in the next cycle. If `ppu_ack` arrives on the final cycle, it wins: data is captured and no timeout is counted.
- `cpu_req` held high through `cpu_ack` is sampled as a new request in the cycle after ack (first IDLE cycle). Throughput is at most 1 access per 2 cycles (unmapped) or 3 cycles (RAM).
- `ppu_ack` outside PPU_WAIT is ignored.

## Test plan
- Write $0005=0xA5, then read $0805 → `cpu_rdata`=0xA5. `cpu_ack` 2 cycles after each request is sampled. Mirror confirmed at $1805.
- Read $2002 with `ppu_ack` 3 cycles after `ppu_req` rises, `ppu_rdata`=0x80 → `ppu_addr`=2, `ppu_we`=0, `cpu_rdata`=0x80, `cpu_ack` 1 cycle after `ppu_ack`, `to_cnt`=0.
- Write $3FFF=0x1E, PPU acks immediately → `ppu_addr`=7, `ppu_we`=1, `ppu_wdata`=0x1E. Open-bus becomes 0x1E.
- Write $0000=0x3C, then read $5000 → `cpu_rdata`=0x3C, `cpu_ack` 1 cycle after sampling.
- Read $2007 with PPU silent → `ppu_req` high exactly 16 cycles, `cpu_rdata`=open-bus value, `to_cnt`=1. 256 timeouts → `to_cnt`=255.
- Assert `rst` for 1 cycle in PPU_WAIT → `ppu_req`=0 next cycle, no `cpu_ack`. RAM byte written before reset still reads back.

Source files
------------

// File: rtl/cpu_bus_resp.sv
// Memory-side responder for the CPU bus: mirrored internal RAM, PPU register
// forwarding with a bounded handshake, and open-bus data for unmapped reads.
module cpu_bus_resp #(
  parameter int RAM_AW      = 11,
  parameter int PPU_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        ppu_req,
  output logic        ppu_we,
  output logic [2:0]  ppu_addr,
  output logic [7:0]  ppu_wdata,
  input  logic        ppu_ack,
  input  logic [7:0]  ppu_rdata,
  output logic [7:0]  to_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RAM_ACC  = 2'd1;
  localparam logic [1:0] PPU_WAIT = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  // Wait counter runs 0..PPU_TIMEOUT-1, one value per PPU_WAIT cycle.
  localparam int              WCW       = $clog2(PPU_TIMEOUT);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(PPU_TIMEOUT - 1);

  logic [1:0]        state;
  logic [WCW-1:0]    wait_cnt;
  logic [7:0]        open_bus;
  logic [7:0]        mem [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_ram;
  logic              sel_ppu;
  logic              addr_unused;

  assign ram_idx     = cpu_addr[RAM_AW-1:0];
  assign sel_ram     = (cpu_addr[15:13] == 3'b000);
  assign sel_ppu     = (cpu_addr[15:13] == 3'b001);
  assign addr_unused = ^cpu_addr;

  assign cpu_ack = (state == RESP);
  assign ppu_req = (state == PPU_WAIT);

  // RAM contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (!rst && state == RAM_ACC && cpu_we) begin
      mem[ram_idx] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      open_bus  <= 8'h00;
      cpu_rdata <= 8'h00;
      ppu_we    <= 1'b0;
      ppu_addr  <= 3'd0;
      ppu_wdata <= 8'h00;
      to_cnt    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (sel_ram) begin
              state <= RAM_ACC;
            end else if (sel_ppu) begin
              state     <= PPU_WAIT;
              wait_cnt  <= '0;
              ppu_we    <= cpu_we;
              ppu_addr  <= cpu_addr[2:0];
              ppu_wdata <= cpu_wdata;
            end else begin
              state <= RESP;
              if (!cpu_we) cpu_rdata <= open_bus;
            end
          end
        end
        RAM_ACC: begin
          state <= RESP;
          if (!cpu_we) cpu_rdata <= mem[ram_idx];
        end
        PPU_WAIT: begin
          // An ack on the last wait cycle takes priority over the timeout.
          if (ppu_ack) begin
            state <= RESP;
            if (!ppu_we) cpu_rdata <= ppu_rdata;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= RESP;
            if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
            if (!ppu_we) cpu_rdata <= open_bus;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        RESP: begin
          state    <= IDLE;
          open_bus <= cpu_we ? cpu_wdata : cpu_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_resp.sv
// Self-checking bench for cpu_bus_resp: scoreboard of expected read data and
// ack latency, plus per-scenario checks of PPU handshake and reset behaviour.
module tb_cpu_bus_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ppu_req;
  logic        ppu_we;
  logic [2:0]  ppu_addr;
  logic [7:0]  ppu_wdata;
  logic        ppu_ack = 1'b0;
  logic [7:0]  ppu_rdata = 8'h00;
  logic [7:0]  to_cnt;

  typedef struct {
    logic [7:0] rdata;
    bit         chk;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         req_edge = 0;
  logic [7:0] ob = 8'h00;

  cpu_bus_resp #(.RAM_AW(11), .PPU_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
    .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata), .to_cnt(to_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every cpu_ack pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ack cyc=%0d rdata=%h required=no ack", cyc, cpu_rdata);
      end else begin
        e = exp_q.pop_front();
        if (e.chk && cpu_rdata !== e.rdata) begin
          errors++;
          $display("[TB] FAIL sb_rdata got=%h exp=%h", cpu_rdata, e.rdata);
        end
        if (e.lat >= 0 && (cyc - req_edge + 1) != e.lat) begin
          errors++;
          $display("[TB] FAIL sb_latency got=%0d exp=%0d", cyc - req_edge + 1, e.lat);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                              input logic [7:0] exp_rdata, input bit chk, input int exp_lat,
                              input int ppu_delay, input logic [7:0] prd, output int ppu_cycles);
    bit   done;
    exp_t e;
    e.rdata = exp_rdata;
    e.chk   = chk;
    e.lat   = exp_lat;
    @(negedge clk);
    exp_q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    req_edge = cyc + 1;
    ppu_cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        done = 1'b1;
      end else if (ppu_req) begin
        ppu_ack   = (ppu_delay >= 0 && ppu_cycles == ppu_delay);
        ppu_rdata = prd;
        ppu_cycles++;
      end else begin
        ppu_ack = 1'b0;
      end
    end
    cpu_req = 1'b0;
    ppu_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL ack_wait addr=%h got=no ack exp=ack within 64 cycles", addr);
      void'(exp_q.pop_back());
    end else begin
      ob = we ? wdata : exp_rdata;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got=%b exp=0", cpu_ack); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata got=%h exp=00", cpu_rdata); end
    checks++; if (ppu_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_ppu_req got=%b exp=0", ppu_req); end
    checks++; if (ppu_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ppu_we got=%b exp=0", ppu_we); end
    checks++; if (ppu_addr !== 3'd0) begin errors++; $display("[TB] FAIL reset_ppu_addr got=%0d exp=0", ppu_addr); end
    checks++; if (ppu_wdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_ppu_wdata got=%h exp=00", ppu_wdata); end
    checks++; if (to_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_to_cnt got=%0d exp=0", to_cnt); end
    rst = 1'b0;
    ob = 8'h00;
  endtask

  task automatic test_ram;
    int pc;
    drive_access(1'b1, 16'h0005, 8'hA5, 8'h00, 1'b0, 2, -1, 8'h00, pc);
    drive_access(1'b0, 16'h0805, 8'h00, 8'hA5, 1'b1, 2, -1, 8'h00, pc);
    drive_access(1'b0, 16'h1805, 8'h00, 8'hA5, 1'b1, 2, -1, 8'h00, pc);
  endtask

  task automatic test_ppu_read;
    int pc;
    drive_access(1'b0, 16'h2002, 8'h00, 8'h80, 1'b1, 5, 3, 8'h80, pc);
    checks++; if (ppu_addr !== 3'd2) begin errors++; $display("[TB] FAIL pr_addr got=%0d exp=2", ppu_addr); end
    checks++; if (ppu_we !== 1'b0) begin errors++; $display("[TB] FAIL pr_we got=%b exp=0", ppu_we); end
    checks++; if (pc != 4) begin errors++; $display("[TB] FAIL pr_req_cycles got=%0d exp=4", pc); end
    checks++; if (to_cnt !== 8'd0) begin errors++; $display("[TB] FAIL pr_to_cnt got=%0d exp=0", to_cnt); end
  endtask

  task automatic test_ppu_write;
    int pc;
    drive_access(1'b1, 16'h3FFF, 8'h1E, 8'h00, 1'b0, 2, 0, 8'hEE, pc);
    checks++; if (ppu_addr !== 3'd7) begin errors++; $display("[TB] FAIL pw_addr got=%0d exp=7", ppu_addr); end
    checks++; if (ppu_we !== 1'b1) begin errors++; $display("[TB] FAIL pw_we got=%b exp=1", ppu_we); end
    checks++; if (ppu_wdata !== 8'h1E) begin errors++; $display("[TB] FAIL pw_wdata got=%h exp=1E", ppu_wdata); end
    drive_access(1'b0, 16'h5000, 8'h00, ob, 1'b1, 1, -1, 8'h00, pc);
  endtask

  task automatic test_unmapped;
    int pc;
    drive_access(1'b1, 16'h0000, 8'h3C, 8'h00, 1'b0, 2, -1, 8'h00, pc);
    drive_access(1'b0, 16'h5000, 8'h00, 8'h3C, 1'b1, 1, -1, 8'h00, pc);
    drive_access(1'b1, 16'h8000, 8'h77, 8'h00, 1'b0, 1, -1, 8'h00, pc);
    drive_access(1'b0, 16'hFFFF, 8'h00, 8'h77, 1'b1, 1, -1, 8'h00, pc);
    drive_access(1'b0, 16'h0000, 8'h00, 8'h3C, 1'b1, 2, -1, 8'h00, pc);
  endtask

  task automatic test_ack_last_cycle;
    int pc;
    drive_access(1'b0, 16'h2003, 8'h00, 8'h5A, 1'b1, 17, 15, 8'h5A, pc);
    checks++; if (pc != 16) begin errors++; $display("[TB] FAIL last_req_cycles got=%0d exp=16", pc); end
    checks++; if (to_cnt !== 8'd0) begin errors++; $display("[TB] FAIL last_to_cnt got=%0d exp=0", to_cnt); end
  endtask

  task automatic test_timeout;
    int pc;
    drive_access(1'b0, 16'h2007, 8'h00, ob, 1'b1, 17, -1, 8'h00, pc);
    checks++; if (pc != 16) begin errors++; $display("[TB] FAIL to_req_cycles got=%0d exp=16", pc); end
    checks++; if (to_cnt !== 8'd1) begin errors++; $display("[TB] FAIL to_cnt_first got=%0d exp=1", to_cnt); end
    for (int i = 0; i < 254; i++) begin
      drive_access(1'b0, 16'h2007, 8'h00, ob, 1'b1, 17, -1, 8'h00, pc);
    end
    checks++; if (to_cnt !== 8'd255) begin errors++; $display("[TB] FAIL to_cnt_255 got=%0d exp=255", to_cnt); end
    drive_access(1'b0, 16'h3FF7, 8'h00, ob, 1'b1, 17, -1, 8'h00, pc);
    checks++; if (to_cnt !== 8'd255) begin errors++; $display("[TB] FAIL to_cnt_sat got=%0d exp=255", to_cnt); end
  endtask

  task automatic test_back_to_back;
    int   acks[$];
    exp_t e;
    e.rdata = 8'hA5; e.chk = 1'b1; e.lat = -1;
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005; ppu_ack = 1'b1;
    req_edge = cyc + 1;
    for (int i = 0; i < 20 && acks.size() < 2; i++) begin
      @(negedge clk);
      if (cpu_ack) acks.push_back(cyc);
    end
    cpu_req = 1'b0;
    checks++;
    if (acks.size() != 2) begin
      errors++; $display("[TB] FAIL b2b_ram_acks got=%0d exp=2", acks.size());
    end else begin
      checks++; if (acks[0] - req_edge + 1 != 2) begin errors++; $display("[TB] FAIL b2b_ram_first got=%0d exp=2", acks[0] - req_edge + 1); end
      checks++; if (acks[1] - acks[0] != 3) begin errors++; $display("[TB] FAIL b2b_ram_gap got=%0d exp=3", acks[1] - acks[0]); end
    end
    acks.delete();
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
    req_edge = cyc + 1;
    for (int i = 0; i < 20 && acks.size() < 2; i++) begin
      @(negedge clk);
      if (cpu_ack) acks.push_back(cyc);
    end
    cpu_req = 1'b0;
    ppu_ack = 1'b0;
    checks++;
    if (acks.size() != 2) begin
      errors++; $display("[TB] FAIL b2b_unm_acks got=%0d exp=2", acks.size());
    end else begin
      checks++; if (acks[0] - req_edge + 1 != 1) begin errors++; $display("[TB] FAIL b2b_unm_first got=%0d exp=1", acks[0] - req_edge + 1); end
      checks++; if (acks[1] - acks[0] != 2) begin errors++; $display("[TB] FAIL b2b_unm_gap got=%0d exp=2", acks[1] - acks[0]); end
    end
    ob = 8'hA5;
  endtask

  task automatic test_reset_in_flight;
    int pc;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2001;
    repeat (3) @(negedge clk);
    checks++; if (ppu_req !== 1'b1) begin errors++; $display("[TB] FAIL rif_req_before got=%b exp=1", ppu_req); end
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (ppu_req !== 1'b0) begin errors++; $display("[TB] FAIL rif_req_after got=%b exp=0", ppu_req); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL rif_ack got=%b exp=0", cpu_ack); end
    checks++; if (to_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rif_to_cnt got=%0d exp=0", to_cnt); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rif_rdata got=%h exp=00", cpu_rdata); end
    rst = 1'b0;
    ob = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL rif_late_ack got=%b exp=0", cpu_ack); end
    drive_access(1'b0, 16'h0805, 8'h00, 8'hA5, 1'b1, 2, -1, 8'h00, pc);
    drive_access(1'b0, 16'h6000, 8'h00, 8'hA5, 1'b1, 1, -1, 8'h00, pc);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_ppu_read();
    test_ppu_write();
    test_unmapped();
    test_ack_last_cycle();
    test_timeout();
    test_back_to_back();
    test_reset_in_flight();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
